// File: rtl/debounce_pkg.sv
// Shared types and default parameter values for the multi-channel debouncer.
// Default counts suit a mechanical button sampled at a few hundred kHz.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW         = 2'd0,
    ST_LOW_TO_HIGH = 2'd1,
    ST_HIGH        = 2'd2,
    ST_HIGH_TO_LOW = 2'd3
  } db_state_t;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_RISE_CLKS   = 25;
  localparam int DEF_FALL_CLKS   = 50;
  localparam int DEF_PULSE_CLKS  = 1;

endpackage

// File: rtl/debounce_channel.sv
// One channel: synchroniser, rise/fall stability FSM, press/release pulse stretchers.
// Level changes SYNC_STAGES+RISE/FALL_CLKS-1 edges after a clean input edge; no backpressure.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RISE_CLKS   = DEF_RISE_CLKS,
  parameter int FALL_CLKS   = DEF_FALL_CLKS,
  parameter int PULSE_CLKS  = DEF_PULSE_CLKS
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_db_level,
  output logic o_press_pulse,
  output logic o_release_pulse
);

  localparam logic [CNT_W-1:0] RISE_LAST  = CNT_W'(RISE_CLKS - 1);
  localparam logic [CNT_W-1:0] FALL_LAST  = CNT_W'(FALL_CLKS - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam bit               RISE_ONE   = (RISE_CLKS == 1);
  localparam bit               FALL_ONE   = (FALL_CLKS == 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  db_state_t              r_state;
  db_state_t              w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_press_evt;
  logic                   w_release_evt;
  logic                   r_db_level;
  logic                   r_press_pulse;
  logic                   r_release_pulse;
  logic [CNT_W-1:0]       r_press_cnt;
  logic [CNT_W-1:0]       r_release_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Counter holds the number of consecutive opposing samples seen so far.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_evt   = 1'b0;
    w_release_evt = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (w_s) begin
          w_state_nxt = ST_LOW_TO_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_LOW_TO_HIGH: begin
        if (!w_s) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == RISE_LAST || RISE_ONE) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
          w_press_evt = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!w_s) begin
          w_state_nxt = ST_HIGH_TO_LOW;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_HIGH_TO_LOW: begin
        if (w_s) begin
          w_state_nxt   = ST_HIGH;
          w_cnt_nxt     = '0;
        end else if (r_cnt == FALL_LAST || FALL_ONE) begin
          w_state_nxt   = ST_LOW;
          w_cnt_nxt     = '0;
          w_release_evt = 1'b1;
        end else begin
          w_cnt_nxt     = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           r_db_level <= 1'b0;
    else if (w_press_evt)   r_db_level <= 1'b1;
    else if (w_release_evt) r_db_level <= 1'b0;
  end

  // A new event reloads its counter, so a retrigger restarts the full width.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_press_pulse <= 1'b0;
      r_press_cnt   <= '0;
    end else if (w_press_evt) begin
      r_press_pulse <= 1'b1;
      r_press_cnt   <= PULSE_LAST;
    end else if (r_press_cnt != '0) begin
      r_press_cnt   <= r_press_cnt - CNT_ONE;
    end else begin
      r_press_pulse <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_release_pulse <= 1'b0;
      r_release_cnt   <= '0;
    end else if (w_release_evt) begin
      r_release_pulse <= 1'b1;
      r_release_cnt   <= PULSE_LAST;
    end else if (r_release_cnt != '0) begin
      r_release_cnt   <= r_release_cnt - CNT_ONE;
    end else begin
      r_release_pulse <= 1'b0;
    end
  end

  assign o_db_level      = r_db_level;
  assign o_press_pulse   = r_press_pulse;
  assign o_release_pulse = r_release_pulse;

endmodule

// File: rtl/debounce_multi.sv
// N independent debounce channels for board buttons/switches feeding the MMIO input register.
// Per-channel latency as in debounce_channel; outputs registered, no backpressure.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RISE_CLKS   = DEF_RISE_CLKS,
  parameter int FALL_CLKS   = DEF_FALL_CLKS,
  parameter int PULSE_CLKS  = DEF_PULSE_CLKS
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_db_level,
  output logic [N_CH-1:0] o_press_pulse,
  output logic [N_CH-1:0] o_release_pulse
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (N_CH < 1) begin : g_bad_n_ch
    $error("debounce_multi: N_CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_multi: SYNC_STAGES must be >= 2");
  end
  if (RISE_CLKS < 1 || RISE_CLKS > CNT_MAX) begin : g_bad_rise
    $error("debounce_multi: RISE_CLKS out of range for CNT_W");
  end
  if (FALL_CLKS < 1 || FALL_CLKS > CNT_MAX) begin : g_bad_fall
    $error("debounce_multi: FALL_CLKS out of range for CNT_W");
  end
  if (PULSE_CLKS < 1 || PULSE_CLKS > CNT_MAX) begin : g_bad_pulse
    $error("debounce_multi: PULSE_CLKS out of range for CNT_W");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RISE_CLKS   (RISE_CLKS),
      .FALL_CLKS   (FALL_CLKS),
      .PULSE_CLKS  (PULSE_CLKS)
    ) u_ch (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_btn           (i_btn[g]),
      .o_db_level      (o_db_level[g]),
      .o_press_pulse   (o_press_pulse[g]),
      .o_release_pulse (o_release_pulse[g])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench: three debouncer configurations driven by one shared button bus.
// Hand-derived tables/sequences plus a stability-run reference model checked every cycle.
module tb_debounce_multi;

  localparam int SYNC = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] btn   = '0;
  logic [3:0] lvl_d [3];
  logic [3:0] pp_d  [3];
  logic [3:0] rp_d  [3];

  int total = 0;
  int bad   = 0;

  // Instance 0: rise 4 / fall 6 / pulse 1; 1: rise 2 / fall 2 / pulse 10; 2: rise 4 / fall 6 / pulse 3.
  debounce_multi #(.N_CH(4), .SYNC_STAGES(2), .CNT_W(8), .RISE_CLKS(4), .FALL_CLKS(6), .PULSE_CLKS(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn),
    .o_db_level(lvl_d[0]), .o_press_pulse(pp_d[0]), .o_release_pulse(rp_d[0]));
  debounce_multi #(.N_CH(4), .SYNC_STAGES(2), .CNT_W(8), .RISE_CLKS(2), .FALL_CLKS(2), .PULSE_CLKS(10)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn),
    .o_db_level(lvl_d[1]), .o_press_pulse(pp_d[1]), .o_release_pulse(rp_d[1]));
  debounce_multi #(.N_CH(4), .SYNC_STAGES(2), .CNT_W(8), .RISE_CLKS(4), .FALL_CLKS(6), .PULSE_CLKS(3)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn),
    .o_db_level(lvl_d[2]), .o_press_pulse(pp_d[2]), .o_release_pulse(rp_d[2]));

  always #5 clk = ~clk;

  function automatic int rise_of(input int i); return (i == 1) ? 2 : 4; endfunction
  function automatic int fall_of(input int i); return (i == 1) ? 2 : 6; endfunction
  function automatic int pulse_of(input int i); return (i == 0) ? 1 : ((i == 1) ? 10 : 3); endfunction

  // Reference model: a level flips once the sampled input has disagreed with it for
  // the required number of consecutive samples; a pulse is high while fewer than
  // PULSE cycles have elapsed since its most recent event.
  logic [3:0] bq [$];
  int         run_hi [3][4];
  int         run_lo [3][4];
  int         age_p  [3][4];
  int         age_r  [3][4];
  bit         lvl_m  [3][4];
  logic [3:0] e_lvl  [3];
  logic [3:0] e_pp   [3];
  logic [3:0] e_rp   [3];
  int         n_press_m [4];
  int         n_rel_m   [4];
  int         npp_d     [4];
  int         nrp_d     [4];
  bit         cnt_en = 1'b0;

  task automatic model_reset();
    bq.delete();
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        run_hi[i][c] = 0;
        run_lo[i][c] = 0;
        age_p[i][c]  = 1000;
        age_r[i][c]  = 1000;
        lvl_m[i][c]  = 1'b0;
      end
      e_lvl[i] = '0;
      e_pp[i]  = '0;
      e_rp[i]  = '0;
    end
  endtask

  task automatic model_step();
    logic [3:0] samp;
    int nr;
    int nf;
    if (!rst_n) begin
      model_reset();
      return;
    end
    bq.push_back(btn);
    if (bq.size() > SYNC) samp = bq.pop_front();
    else                  samp = '0;
    for (int i = 0; i < 3; i++) begin
      nr = (rise_of(i) == 1) ? 2 : rise_of(i);
      nf = (fall_of(i) == 1) ? 2 : fall_of(i);
      for (int c = 0; c < 4; c++) begin
        if (samp[c]) begin
          if (run_hi[i][c] < 1000) run_hi[i][c]++;
          run_lo[i][c] = 0;
        end else begin
          if (run_lo[i][c] < 1000) run_lo[i][c]++;
          run_hi[i][c] = 0;
        end
        if (age_p[i][c] < 1000) age_p[i][c]++;
        if (age_r[i][c] < 1000) age_r[i][c]++;
        if (!lvl_m[i][c] && run_hi[i][c] == nr) begin
          lvl_m[i][c] = 1'b1;
          age_p[i][c] = 0;
          if (i == 0) n_press_m[c]++;
        end else if (lvl_m[i][c] && run_lo[i][c] == nf) begin
          lvl_m[i][c] = 1'b0;
          age_r[i][c] = 0;
          if (i == 0) n_rel_m[c]++;
        end
        e_lvl[i][c] = lvl_m[i][c];
        e_pp[i][c]  = (age_p[i][c] < pulse_of(i));
        e_rp[i][c]  = (age_r[i][c] < pulse_of(i));
      end
    end
  endtask

  function automatic int pack(input logic [3:0] l, input logic [3:0] p, input logic [3:0] r);
    return {20'd0, l, p, r};
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t: got %03h (lvl/press/rel nibbles), expected %03h", name, $time, got, want);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++)
      chk($sformatf("model_inst%0d", i), pack(lvl_d[i], pp_d[i], rp_d[i]), pack(e_lvl[i], e_pp[i], e_rp[i]));
    if (cnt_en) begin
      for (int c = 0; c < 4; c++) begin
        if (pp_d[0][c]) npp_d[c]++;
        if (rp_d[0][c]) nrp_d[c]++;
      end
    end
  endtask

  // Inputs change only at the falling edge; outputs are compared at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] ppa;
    logic [3:0] rpa;
    logic [3:0] ppc;
    logic [3:0] rpc;
  } vec_t;

  vec_t tbl [42];

  task automatic fill(input int lo, input int hi, input logic [3:0] b, input logic [3:0] l,
                      input logic [3:0] pa, input logic [3:0] ra, input logic [3:0] pc, input logic [3:0] rc);
    for (int k = lo; k <= hi; k++) tbl[k] = '{b, l, pa, ra, pc, rc};
  endtask

  int         hold [4];
  int         base_p [4];
  int         base_r [4];
  logic [3:0] el;
  logic [3:0] ep;
  logic [3:0] er;

  initial begin
    // Row k: button value applied before edge k, outputs expected after edge k.
    // Channel 0 clean press then release; rows 20.. channel 1 bounce then steady press/release.
    fill( 0,  4, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    fill( 5,  5, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    fill( 6,  7, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    fill( 8,  9, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    fill(10, 16, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    fill(17, 17, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    fill(18, 19, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    fill(20, 22, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    fill(23, 23, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    fill(24, 28, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    fill(29, 29, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000);
    fill(30, 31, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    fill(32, 38, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    fill(39, 39, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
    fill(40, 41, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010);

    #3 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_inst%0d", i), pack(lvl_d[i], pp_d[i], rp_d[i]), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    for (int k = 0; k < 42; k++) begin
      btn = tbl[k].btn;
      tick();
      chk($sformatf("tbl%0d_a", k), pack(lvl_d[0], pp_d[0], rp_d[0]), pack(tbl[k].lvl, tbl[k].ppa, tbl[k].rpa));
      chk($sformatf("tbl%0d_c", k), pack(lvl_d[2], pp_d[2], rp_d[2]), pack(tbl[k].lvl, tbl[k].ppc, tbl[k].rpc));
    end
    repeat (15) tick();

    // Channel 2 on the rise/fall 2, pulse 10 instance: press@3, release@7, press@10.
    for (int k = 0; k < 22; k++) begin
      btn = (k <= 3 || k >= 7) ? 4'b0100 : 4'b0000;
      tick();
      el = (((k >= 3) && (k <= 6)) || (k >= 10)) ? 4'b0100 : 4'b0000;
      ep = ((k >= 3) && (k <= 19)) ? 4'b0100 : 4'b0000;
      er = ((k >= 7) && (k <= 16)) ? 4'b0100 : 4'b0000;
      chk($sformatf("retrig%0d_b", k), pack(lvl_d[1] & 4'b0100, pp_d[1] & 4'b0100, rp_d[1] & 4'b0100), pack(el, ep, er));
    end
    btn = '0;
    repeat (25) tick();

    // Asynchronous reset in the middle of a press pulse, button held through release.
    btn = 4'b1000;
    for (int k = 0; k < 6; k++) tick();
    chk("pre_rst_press_c", {31'd0, pp_d[2][3]}, 1);
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("mid_rst_inst%0d", i), pack(lvl_d[i], pp_d[i], rp_d[i]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("rearm%0d_a", k), {30'd0, lvl_d[0][3], pp_d[0][3]}, {30'd0, (k >= 5), (k == 5)});
      chk($sformatf("rearm%0d_b", k), {31'd0, lvl_d[1][3]}, {31'd0, (k >= 3)});
    end
    btn = '0;
    repeat (25) tick();

    // Staggered random bouncing on every channel.
    for (int c = 0; c < 4; c++) begin
      hold[c]   = 3 * c + 1;
      base_p[c] = n_press_m[c];
      base_r[c] = n_rel_m[c];
      npp_d[c]  = 0;
      nrp_d[c]  = 0;
    end
    cnt_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          btn[c]  = ~btn[c];
          hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 16));
        end else begin
          hold[c]--;
        end
      end
      tick();
    end
    btn = '0;
    repeat (30) tick();
    cnt_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("press_count_ch%0d", c), npp_d[c], n_press_m[c] - base_p[c]);
      chk($sformatf("release_count_ch%0d", c), nrp_d[c], n_rel_m[c] - base_r[c]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
